// File: rtl/seq_pkg.sv
`default_nettype none
// =============================================================================
// seq_pkg : shared encodings and segment descriptor for segment_sequencer
// Rev 1.0
// =============================================================================
package seq_pkg;

  // Descriptor field widths; the top's TW/RW parameters default to these.
  localparam int DUR_W = 16;
  localparam int RPT_W = 8;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_REPEAT  = 2'd1,
    MODE_LOOP    = 2'd2,
    MODE_CHAIN   = 2'd3
  } mode_e;

  localparam logic [1:0] SEL_AMP    = 2'd0;
  localparam logic [1:0] SEL_OFFSET = 2'd1;
  localparam logic [1:0] SEL_PHASE  = 2'd2;

  typedef struct packed {
    logic [DUR_W-1:0] dur;
    logic [RPT_W-1:0] rpt;
    mode_e            mode;
  } desc_t;

endpackage
`default_nettype wire

// File: rtl/param_bank.sv
`default_nettype none
// =============================================================================
// param_bank : shadow/active register pair for one per-channel field
// Rev 1.0
// =============================================================================
module param_bank #(
  parameter int NCH = 64,
  parameter int DW  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic [$clog2(NCH)-1:0] addr_i,
  input  logic [DW-1:0]          data_i,
  input  logic                   xfer_i,
  output logic [NCH*DW-1:0]      active_o
);

  logic [NCH-1:0][DW-1:0] shadow_q;
  logic [NCH-1:0][DW-1:0] active_q;

  // Writes and transfers never coincide: writes are only accepted while
  // nothing is pending, transfers only happen when something is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (we_i) shadow_q[addr_i] <= data_i;
      if (xfer_i) active_q <= shadow_q;
    end
  end

  assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/segment_sequencer.sv
`default_nettype none
// =============================================================================
// segment_sequencer : shadow/active parameter banks plus segment run FSM
// Rev 1.0
// =============================================================================
module segment_sequencer
  import seq_pkg::*;
#(
  parameter int NCH = 64,
  parameter int DW  = 16,
  parameter int TW  = DUR_W,
  parameter int RW  = RPT_W
) (
  input  logic                   clk1,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [1:0]             wr_sel,
  input  logic [$clog2(NCH)-1:0] wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic [TW-1:0]          dur_in,
  input  logic [RW-1:0]          rpt_in,
  input  logic [1:0]             mode_in,
  input  logic                   commit,
  input  logic                   start,
  input  logic                   abort,
  output logic [NCH*DW-1:0]      amps_out,
  output logic [NCH*DW-1:0]      offsets_out,
  output logic [NCH*DW-1:0]      phasewords_out,
  output logic                   running,
  output logic                   capture_en,
  output logic                   gen_reset,
  output logic                   seg_done,
  output logic                   run_done,
  output logic                   pending,
  output logic                   wr_drop,
  output logic [TW-1:0]          remaining
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e        state_q;
  desc_t         pend_q, act_q;
  logic          pending_q, running_q, gen_reset_q, seg_done_q, run_done_q, wr_drop_q;
  logic [TW-1:0] remaining_q;
  logic [RW-1:0] seg_cnt_q;

  logic [TW-1:0] act_dur, pend_dur;
  logic [RW-1:0] act_rpt;
  logic          start_ok, seg_end, reload_same, chain_go, xfer, bank_we;

  // Zero durations and repeat counts are played as one.
  assign act_dur  = (act_q.dur == '0) ? TW'(1) : TW'(act_q.dur);
  assign pend_dur = (pend_q.dur == '0) ? TW'(1) : TW'(pend_q.dur);
  assign act_rpt  = (act_q.rpt == '0) ? RW'(1) : RW'(act_q.rpt);

  assign start_ok    = start && !abort && (state_q != ST_RUN);
  assign seg_end     = (state_q == ST_RUN) && (remaining_q == TW'(1));
  assign reload_same = (act_q.mode == MODE_LOOP) ||
                       ((act_q.mode == MODE_REPEAT) && (seg_cnt_q < act_rpt));
  assign chain_go    = (act_q.mode == MODE_CHAIN) && pending_q;
  assign xfer        = pending_q && ((start_ok) || (seg_end && !abort && chain_go));
  assign bank_we     = wr_en && !pending_q;

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      act_q       <= '0;
      pending_q   <= 1'b0;
      running_q   <= 1'b0;
      gen_reset_q <= 1'b0;
      seg_done_q  <= 1'b0;
      run_done_q  <= 1'b0;
      wr_drop_q   <= 1'b0;
      remaining_q <= '0;
      seg_cnt_q   <= '0;
    end else begin
      gen_reset_q <= 1'b0;
      seg_done_q  <= 1'b0;
      run_done_q  <= 1'b0;
      wr_drop_q   <= pending_q && (wr_en || commit);

      // A commit on a boundary edge sees pending_q==0 there, so it only
      // becomes eligible for the following boundary.
      if (commit && !pending_q) begin
        pending_q   <= 1'b1;
        pend_q.dur  <= DUR_W'(dur_in);
        pend_q.rpt  <= RPT_W'(rpt_in);
        pend_q.mode <= mode_e'(mode_in);
      end

      if (abort) begin
        state_q     <= ST_HOLD;
        running_q   <= 1'b0;
        remaining_q <= '0;
      end else if (start_ok) begin
        state_q     <= ST_RUN;
        running_q   <= 1'b1;
        gen_reset_q <= 1'b1;
        seg_cnt_q   <= RW'(1);
        if (pending_q) begin
          act_q       <= pend_q;
          pending_q   <= 1'b0;
          remaining_q <= pend_dur;
        end else begin
          remaining_q <= act_dur;
        end
      end else if (state_q == ST_RUN) begin
        if (!seg_end) begin
          remaining_q <= remaining_q - TW'(1);
        end else begin
          seg_done_q <= 1'b1;
          if (reload_same) begin
            remaining_q <= act_dur;
            gen_reset_q <= 1'b1;
            seg_cnt_q   <= seg_cnt_q + RW'(1);
          end else if (chain_go) begin
            act_q       <= pend_q;
            pending_q   <= 1'b0;
            remaining_q <= pend_dur;
            gen_reset_q <= 1'b1;
            seg_cnt_q   <= RW'(1);
          end else begin
            state_q     <= ST_HOLD;
            running_q   <= 1'b0;
            run_done_q  <= 1'b1;
            remaining_q <= '0;
          end
        end
      end
    end
  end

  param_bank #(.NCH(NCH), .DW(DW)) u_amp (
    .clk_i(clk1), .rst_ni(reset_n), .we_i(bank_we && (wr_sel == SEL_AMP)),
    .addr_i(wr_addr), .data_i(wr_data), .xfer_i(xfer), .active_o(amps_out)
  );

  param_bank #(.NCH(NCH), .DW(DW)) u_offset (
    .clk_i(clk1), .rst_ni(reset_n), .we_i(bank_we && (wr_sel == SEL_OFFSET)),
    .addr_i(wr_addr), .data_i(wr_data), .xfer_i(xfer), .active_o(offsets_out)
  );

  param_bank #(.NCH(NCH), .DW(DW)) u_phase (
    .clk_i(clk1), .rst_ni(reset_n), .we_i(bank_we && (wr_sel == SEL_PHASE)),
    .addr_i(wr_addr), .data_i(wr_data), .xfer_i(xfer), .active_o(phasewords_out)
  );

  assign running    = running_q;
  assign capture_en = running_q;
  assign gen_reset  = gen_reset_q;
  assign seg_done   = seg_done_q;
  assign run_done   = run_done_q;
  assign pending    = pending_q;
  assign wr_drop    = wr_drop_q;
  assign remaining  = remaining_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_sequencer.sv
`default_nettype none
// =============================================================================
// tb_segment_sequencer : directed and randomized checks of segment_sequencer
// Rev 1.0
// =============================================================================
module tb_segment_sequencer;

  localparam int NCH = 64;
  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int RW  = 8;
  localparam int BW  = NCH * DW;

  logic          clk1    = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en   = 1'b0;
  logic [1:0]    wr_sel  = '0;
  logic [5:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [TW-1:0] dur_in  = '0;
  logic [RW-1:0] rpt_in  = '0;
  logic [1:0]    mode_in = '0;
  logic          commit  = 1'b0;
  logic          start   = 1'b0;
  logic          abort   = 1'b0;
  logic [BW-1:0] amps_out, offsets_out, phasewords_out;
  logic          running, capture_en, gen_reset, seg_done, run_done, pending, wr_drop;
  logic [TW-1:0] remaining;

  segment_sequencer #(.NCH(NCH), .DW(DW), .TW(TW), .RW(RW)) dut (
    .clk1(clk1), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .dur_in(dur_in), .rpt_in(rpt_in),
    .mode_in(mode_in), .commit(commit), .start(start), .abort(abort),
    .amps_out(amps_out), .offsets_out(offsets_out), .phasewords_out(phasewords_out),
    .running(running), .capture_en(capture_en), .gen_reset(gen_reset),
    .seg_done(seg_done), .run_done(run_done), .pending(pending),
    .wr_drop(wr_drop), .remaining(remaining)
  );

  always #5 clk1 = ~clk1;

  // Event counters sampled on the falling edge.
  int   n_gr = 0, n_seg = 0, n_done = 0, n_run = 0, n_rise = 0, n_drop = 0;
  logic prev_run = 1'b0;
  always @(negedge clk1) begin
    if (gen_reset) n_gr++;
    if (seg_done) n_seg++;
    if (run_done) n_done++;
    if (running) n_run++;
    if (running && !prev_run) n_rise++;
    if (wr_drop) n_drop++;
    prev_run = running;
  end

  int b_gr, b_seg, b_done, b_run, b_rise, b_drop;
  int checks = 0;
  int errors = 0;

  // Reference model: shadow/active field arrays and the pending flag.
  logic [DW-1:0] sh [3][NCH];
  logic [DW-1:0] ac [3][NCH];
  bit            m_pend;

  task automatic model_reset();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < NCH; k++) begin
        sh[f][k] = '0;
        ac[f][k] = '0;
      end
    m_pend = 1'b0;
  endtask

  function automatic logic [BW-1:0] mbus(input int f);
    logic [BW-1:0] v = '0;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = ac[f][k];
    return v;
  endfunction

  function automatic logic [DW-1:0] chn(input logic [BW-1:0] b, input int k);
    return b[k*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    int bad;
    bad = -1;
    for (int k = NCH - 1; k >= 0; k--)
      if (obs[k*DW +: DW] !== exp[k*DW +: DW]) bad = k;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: channel %0d observed %0h expected %0h", tag, bad,
             (bad >= 0) ? obs[bad*DW +: DW] : 16'h0, (bad >= 0) ? exp[bad*DW +: DW] : 16'h0);
    end
  endtask

  task automatic snap();
    b_gr = n_gr; b_seg = n_seg; b_done = n_done;
    b_run = n_run; b_rise = n_rise; b_drop = n_drop;
  endtask

  task automatic step();
    @(negedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int sel, input int ch, input int d);
    wr_en = 1'b1; wr_sel = 2'(sel); wr_addr = 6'(ch); wr_data = 16'(d);
    if (!m_pend && sel != 3) sh[sel][ch] = 16'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_commit(input int dur, input int rpt, input int mode);
    commit = 1'b1; dur_in = 16'(dur); rpt_in = 8'(rpt); mode_in = 2'(mode);
    m_pend = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    if (m_pend) begin
      ac = sh;
      m_pend = 1'b0;
    end
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, md, d, r, deff, segs;
    model_reset();
    repeat (2) @(negedge clk1);
    #1;
    chk("reset_running", running, 0);
    chk("reset_pending", pending, 0);
    chk("reset_remaining", remaining, 0);
    chkw("reset_amps", amps_out, '0);
    reset_n = 1'b1;
    step();

    // start + commit together from IDLE: old (zero) bank replays, commit latched
    wr(0, 5, 16'h5555);
    start = 1'b1; commit = 1'b1; dur_in = 16'd3; rpt_in = 8'd0; mode_in = 2'd0;
    step();
    start = 1'b0; commit = 1'b0; m_pend = 1'b1;
    chk("sc_running", running, 1);
    chk("sc_remaining", remaining, 1);
    chk("sc_amp5_old", chn(amps_out, 5), 16'h0000);
    chk("sc_pending", pending, 1);
    idle(2);
    chk("sc_ended", running, 0);

    // abort beats start
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("ab_start_running", running, 0);
    chk("ab_start_pending", pending, 1);
    do_start();
    chk("sc2_remaining", remaining, 3);
    chk("sc2_amp5", chn(amps_out, 5), 16'h5555);
    idle(4);

    // one-shot D=4
    wr(0, 5, 16'h1234);
    do_commit(4, 0, 0);
    chk("os_pending_set", pending, 1);
    snap();
    do_start();
    chk("os_gen_reset", gen_reset, 1);
    chk("os_running", running, 1);
    chk("os_capture", capture_en, 1);
    chk("os_remaining", remaining, 4);
    chk("os_amp5", chn(amps_out, 5), 16'h1234);
    chk("os_pending_clr", pending, 0);
    idle(6);
    chk("os_run_cycles", n_run - b_run, 4);
    chk("os_gr", n_gr - b_gr, 1);
    chk("os_seg", n_seg - b_seg, 1);
    chk("os_done", n_done - b_done, 1);

    // repeat R=3 D=2
    do_commit(2, 3, 1);
    snap();
    do_start();
    idle(8);
    chk("rp_run_cycles", n_run - b_run, 6);
    chk("rp_rises", n_rise - b_rise, 1);
    chk("rp_gr", n_gr - b_gr, 3);
    chk("rp_seg", n_seg - b_seg, 3);
    chk("rp_done", n_done - b_done, 1);

    // chain A(D=3) -> B(D=5) committed during A
    do_commit(3, 0, 3);
    snap();
    do_start();
    wr(0, 7, 16'hBEEF);
    do_commit(5, 0, 0);
    chk("ch_pending", pending, 1);
    chk("ch_amp7_before", chn(amps_out, 7), 16'h0000);
    ac = sh; m_pend = 1'b0;
    idle(10);
    chk("ch_run_cycles", n_run - b_run, 8);
    chk("ch_rises", n_rise - b_rise, 1);
    chk("ch_gr", n_gr - b_gr, 2);
    chk("ch_seg", n_seg - b_seg, 2);
    chk("ch_done", n_done - b_done, 1);
    chkw("ch_amps", amps_out, mbus(0));
    chk("ch_pending_clr", pending, 0);

    // writes/commits while pending are dropped
    wr(0, 9, 16'h1111);
    do_commit(2, 0, 0);
    snap();
    wr(0, 9, 16'h2222);
    chk("dr_write", n_drop - b_drop, 1);
    commit = 1'b1; dur_in = 16'd7; mode_in = 2'd1;
    step();
    commit = 1'b0;
    chk("dr_commit", n_drop - b_drop, 2);
    do_start();
    chk("dr_amp9", chn(amps_out, 9), 16'h1111);
    idle(4);
    chk("dr_run_cycles", n_run - b_run, 2);

    // loop D=2, abort on a segment-end cycle
    wr(0, 3, 16'h0A0A);
    do_commit(2, 0, 2);
    snap();
    do_start();
    idle(5);
    chk("lp_gr", n_gr - b_gr, 3);
    chk("lp_remaining", remaining, 1);
    snap();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("lp_ab_running", running, 0);
    chk("lp_ab_capture", capture_en, 0);
    chk("lp_ab_remaining", remaining, 0);
    idle(3);
    chk("lp_ab_seg", n_seg - b_seg, 0);
    chk("lp_ab_done", n_done - b_done, 0);
    chk("lp_ab_gr", n_gr - b_gr, 0);
    chk("lp_ab_amp3", chn(amps_out, 3), 16'h0A0A);

    // asynchronous reset mid-run
    do_start();
    idle(2);
    reset_n = 1'b0;
    #1;
    chk("ar_running", running, 0);
    chk("ar_remaining", remaining, 0);
    chkw("ar_amps", amps_out, '0);
    model_reset();
    step();
    reset_n = 1'b1;
    step();

    // D=0 plays as one cycle
    do_commit(0, 0, 0);
    snap();
    do_start();
    chk("d0_remaining", remaining, 1);
    idle(3);
    chk("d0_run_cycles", n_run - b_run, 1);
    chk("d0_done", n_done - b_done, 1);

    // randomized runs against the model
    for (int it = 0; it < 8; it++) begin
      nw = int'($urandom_range(5, 1));
      for (int j = 0; j < nw; j++)
        wr(int'($urandom_range(3, 0)), int'($urandom_range(NCH - 1, 0)), int'($urandom_range(16'hFFFF, 0)));
      case ($urandom_range(2, 0))
        0: md = 0;
        1: md = 1;
        default: md = 3;
      endcase
      d = int'($urandom_range(4, 0));
      r = int'($urandom_range(3, 0));
      do_commit(d, r, md);
      snap();
      wr(int'($urandom_range(2, 0)), int'($urandom_range(NCH - 1, 0)), int'($urandom_range(16'hFFFF, 0)));
      chk("rnd_drop", n_drop - b_drop, 1);
      deff = (d == 0) ? 1 : d;
      segs = (md == 1) ? ((r == 0) ? 1 : r) : 1;
      snap();
      do_start();
      idle(deff * segs + 3);
      chk("rnd_run_cycles", n_run - b_run, deff * segs);
      chk("rnd_gr", n_gr - b_gr, segs);
      chk("rnd_seg", n_seg - b_seg, segs);
      chk("rnd_done", n_done - b_done, 1);
      chk("rnd_pending", pending, 0);
      chkw("rnd_amps", amps_out, mbus(0));
      chkw("rnd_offsets", offsets_out, mbus(1));
      chkw("rnd_phases", phasewords_out, mbus(2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segment_sequencer.md
Name: segment_sequencer

Overview:
Parametrised run controller between the host pipe endpoints and the sixtyfourblock oscillator array, all in the clk1 domain. It holds a per-channel shadow bank of amp, offset and phaseword that the host writes one channel at a time, commits it, and swaps it into an active bank. The active bank plays for a programmed number of cycles in one of four modes: one-shot, repeat-N, loop-forever or chained segments. It also produces the oscillator resync pulse, a correctly-polarised capture enable for the output FIFO, and done pulses for the trigger-out endpoint.

Parameters:
NCH, 64, number of oscillator channels
DW, 16, width of amp/offset/phaseword per channel
TW, 16, width of the segment duration counter
RW, 8, width of the repeat count

Ports:
clk1  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  shadow-bank write strobe
wr_sel  in  2  target field: 0 amp, 1 offset, 2 phaseword, 3 reserved (write ignored)
wr_addr  in  $clog2(NCH)  channel index
wr_data  in  DW  value to write
dur_in  in  TW  segment duration in cycles, sampled on commit
rpt_in  in  RW  repeat count, sampled on commit
mode_in  in  2  0 one-shot, 1 repeat-N, 2 loop, 3 chain; sampled on commit
commit  in  1  pulse: freeze shadow bank as the pending segment
start  in  1  pulse: begin a run
abort  in  1  pulse: stop immediately
amps_out  out  NCH*DW  active amps, channel k at [k*DW +: DW]
offsets_out  out  NCH*DW  active offsets
phasewords_out  out  NCH*DW  active phasewords
running  out  1  segment playing
capture_en  out  1  FIFO write enable; equals running
gen_reset  out  1  one-cycle resync pulse to the oscillators at every segment load
seg_done  out  1  one-cycle pulse at every segment end
run_done  out  1  one-cycle pulse at natural run end (not on abort)
pending  out  1  committed segment waiting
wr_drop  out  1  one-cycle pulse: write or commit ignored
remaining  out  TW  cycles left in the current segment

Behaviour:
- Reset: all banks, counters and outputs go to 0, state is IDLE, pending is 0.
- States are IDLE, RUN and HOLD. HOLD behaves like IDLE, except that the active values stay visible on the outputs.
- Shadow writes:
  - Take effect on the next edge while pending=0.
  - While pending=1, the write is ignored and wr_drop pulses.
- commit:
  - When pending=0: pending<=1, and dur_in, rpt_in and mode_in are latched into the pending descriptor.
  - When pending=1: the commit is ignored and wr_drop pulses.
- Duration of 0 is treated as 1. Repeat count of 0 is treated as 1.
- start in IDLE or HOLD, at edge t:
  - If pending=1, shadow and descriptor go to active, and pending<=0.
  - If pending=0, the existing active bank and descriptor are replayed.
  - At t+1: running=1, gen_reset=1 for exactly one cycle, remaining=D.
- start while in RUN is ignored.
- In RUN, remaining decrements every cycle. running is high for exactly D cycles per segment.
- Segment end is the cycle where remaining==1. On the next edge seg_done pulses, then the mode decides:
  - one-shot: run ends.
  - repeat-N: if segments played < R, reload D, pulse gen_reset and stay in RUN; otherwise the run ends.
  - loop: reload D and pulse gen_reset indefinitely.
  - chain: if pending=1, swap shadow to active, load the new descriptor (including its mode), clear pending, pulse gen_reset and continue with no gap cycle. If pending=0, the run ends.
- Run end: running<=0, run_done pulses, state goes to HOLD.
- abort, on the next edge:
  - running<=0, state goes to HOLD, remaining<=0.
  - No seg_done or run_done pulse.
  - pending is preserved.
- Simultaneous events:
  - abort beats start and beats a segment end.
  - A commit landing on the segment-end cycle is not eligible for that boundary's chain swap; it waits for the next boundary.
  - start and commit in the same cycle from IDLE: the commit is latched and the start replays the old active bank.
- Active outputs change only on a load edge, so they are glitch-free across segments.

Decomposition:
- Shared package seq_pkg holds:
  - mode encodings MODE_ONESHOT/REPEAT/LOOP/CHAIN;
  - wr_sel encodings SEL_AMP/OFFSET/PHASE;
  - a descriptor struct {dur, rpt, mode}.
- One sub-module, param_bank: shadow/active register pair for one field with per-channel write and bulk transfer. Instantiate it three times.
- The FSM and counters live in the top of segment_sequencer.

Test Plan:
- Write amp ch5=0x1234, commit D=4 one-shot, start → gen_reset pulses one cycle; amps_out[80+:16]=0x1234; running high exactly 4 cycles; seg_done and run_done pulse once; pending back to 0.
- Repeat mode, R=3, D=2 → 3 gen_reset pulses; running continuous for 6 cycles; seg_done ×3; run_done ×1.
- Chain: commit A (D=3), start, write and commit B (D=5) during A → B appears at the end of A with no gap; running high for 8 cycles; run_done after B.
- Shadow write after commit (pending=1) → wr_drop pulses; the value is absent after the swap. A second commit also gives wr_drop.
- Loop D=2, then abort mid-segment → running drops on the next edge; no run_done pulse; outputs hold the active values.
- Assert reset_n low mid-run → all outputs 0 immediately (asynchronous); D=0 is treated as 1 (running high 1 cycle).
